// File: rtl/agc_core_if.sv
// Sample/gain bundle for agc_core: the receive front-end drives the master side,
// and the AGC core is the slave side.
interface agc_core_if #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 24
);
  logic                s_valid;
  logic [DATA_W-1:0]   s_i;
  logic [DATA_W-1:0]   s_q;
  logic [DATA_W-2:0]   vref;
  logic                freeze;
  logic [GAIN_W-1:0]   gain;
  logic                gain_valid;
  logic [DATA_W:0]     level;
  logic                win_full;

  modport master (
    output s_valid, s_i, s_q, vref, freeze,
    input  gain, gain_valid, level, win_full
  );

  modport slave (
    input  s_valid, s_i, s_q, vref, freeze,
    output gain, gain_valid, level, win_full
  );
endinterface

// File: rtl/agc_core.sv
// Automatic gain control: |I|+|Q| moving-average level detector feeding a
// sequential restoring divider that produces gain = vref / level in fixed point.
module agc_core #(
  parameter int DATA_W   = 16,
  parameter int LOG2_WIN = 6,
  parameter int FRAC_W   = 8,
  parameter int GAIN_W   = 24
) (
  input logic       clk,
  input logic       arst,
  agc_core_if.slave io_agc
);
  localparam int WIN  = 1 << LOG2_WIN;
  localparam int SW   = DATA_W + 1;
  localparam int ACCW = SW + LOG2_WIN;
  localparam int QW   = DATA_W - 1 + FRAC_W;
  localparam int CNTW = $clog2(QW);
  localparam int XW   = (QW > GAIN_W) ? QW : GAIN_W;

  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1) << FRAC_W;
  localparam logic [GAIN_W-1:0] GAIN_MAX  = {GAIN_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  logic [DATA_W-1:0] w_absI, w_absQ;
  logic [DATA_W-1:0] r_absI, r_absQ;
  logic              r_validA, r_validB;
  logic [SW-1:0]     r_sum;
  logic [SW-1:0]     r_line [WIN];
  logic [LOG2_WIN-1:0] r_wp;
  logic [ACCW-1:0]   r_acc;
  logic [LOG2_WIN:0] r_fill;
  logic [SW-1:0]     r_level;
  logic              w_winFull;

  state_t            r_state, w_next;
  logic              w_start;
  logic [SW-1:0]     r_rem, r_div;
  logic [QW-1:0]     r_quo;
  logic [CNTW-1:0]   r_cnt;
  logic              r_zero;
  logic [SW:0]       w_trial;
  logic              w_ge;
  logic [SW-1:0]     w_remNext;
  logic [XW-1:0]     w_quoExt;
  logic [GAIN_W-1:0] w_sat;
  logic [GAIN_W-1:0] r_gain;
  logic              r_gainValid;

  // The most-negative sample has no positive twin, so it clips to full scale.
  assign w_absI = !io_agc.s_i[DATA_W-1] ? io_agc.s_i :
                  (io_agc.s_i == MOST_NEG) ? MOST_POS : -io_agc.s_i;
  assign w_absQ = !io_agc.s_q[DATA_W-1] ? io_agc.s_q :
                  (io_agc.s_q == MOST_NEG) ? MOST_POS : -io_agc.s_q;

  // The fill counter saturates at WIN, so its MSB is exactly "window full".
  assign w_winFull = r_fill[LOG2_WIN];

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_absI   <= '0;
      r_absQ   <= '0;
      r_validA <= 1'b0;
      r_sum    <= '0;
      r_validB <= 1'b0;
      for (int k = 0; k < WIN; k++) r_line[k] <= '0;
      r_wp     <= '0;
      r_acc    <= '0;
      r_fill   <= '0;
      r_level  <= '0;
    end else begin
      r_validA <= io_agc.s_valid;
      if (io_agc.s_valid) begin
        r_absI <= w_absI;
        r_absQ <= w_absQ;
      end
      r_validB <= r_validA;
      if (r_validA) r_sum <= {1'b0, r_absI} + {1'b0, r_absQ};
      if (r_validB) begin
        r_line[r_wp] <= r_sum;
        r_wp         <= r_wp + 1'b1;
        r_acc        <= r_acc + ACCW'(r_sum) - ACCW'(r_line[r_wp]);
        if (!w_winFull) r_fill <= r_fill + 1'b1;
      end
      r_level <= r_acc[ACCW-1:LOG2_WIN];
    end
  end

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  assign w_trial   = {r_rem, r_quo[QW-1]};
  assign w_ge      = (w_trial >= {1'b0, r_div});
  assign w_remNext = w_ge ? SW'(w_trial - {1'b0, r_div}) : w_trial[SW-1:0];
  assign w_quoExt  = XW'(r_quo);
  assign w_sat     = (w_quoExt > XW'(GAIN_MAX)) ? GAIN_MAX : w_quoExt[GAIN_W-1:0];

  always_ff @(posedge clk) begin
    if (!arst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_winFull && !io_agc.freeze) w_next = (r_level == '0) ? DONE : DIV;
      DIV:  if (r_cnt == CNTW'(QW - 1)) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_start = (r_state == IDLE) && (w_next != IDLE);

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_rem       <= '0;
      r_div       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_gain      <= GAIN_ONE;
      r_gainValid <= 1'b0;
    end else begin
      r_gainValid <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_quo  <= {io_agc.vref, {FRAC_W{1'b0}}};
          r_div  <= r_level;
          r_rem  <= '0;
          r_cnt  <= '0;
          r_zero <= (r_level == '0);
        end
        DIV: begin
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_rem <= w_remNext;
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          r_gain      <= r_zero ? GAIN_MAX : w_sat;
          r_gainValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_agc.gain       = r_gain;
  assign io_agc.gain_valid = r_gainValid;
  assign io_agc.level      = r_level;
  assign io_agc.win_full   = w_winFull;
endmodule
